// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Pointer value that makes index k the lowest priority in a descending search.
    function automatic int rr_next_ptr(input int k, input int n);
        return (k == 0) ? (n - 1) : (k - 1);
    endfunction

endpackage

// File: rtl/ps_rot.sv
// Combinational rotating priority selector: descending search from ptr with wrap,
// skipping any bit set in excl.
module ps_rot #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  win,
    output logic [IW-1:0] win_id,
    output logic          win_vld
);

    always_comb begin
        int j;
        logic [IW-1:0] idx;
        win     = '0;
        win_id  = '0;
        win_vld = 1'b0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) - i;
            if (j < 0) j = j + N;
            idx = IW'(j);
            if (!win_vld && req[idx] && !excl[idx]) begin
                win_vld     = 1'b1;
                win_id      = idx;
                win[idx]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Round-robin grant controller with bounded owner bursts; all outputs registered.
module rr_arb4
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 preempt
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_state_t    state, state_n;
    logic [IW-1:0] own, own_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [N-1:0]  gnt_n;
    logic          busy_n, preempt_n;

    logic [N-1:0]  excl;
    logic [N-1:0]  win;
    logic [IW-1:0] win_id;
    logic          win_vld;

    // The current owner is masked out so a hold expiry always picks someone else.
    always_comb begin
        excl = '0;
        if (state == OWNED) excl[own] = 1'b1;
    end

    ps_rot #(.N(N), .IW(IW)) u_sel (
        .req     (req),
        .ptr     (ptr),
        .excl    (excl),
        .win     (win),
        .win_id  (win_id),
        .win_vld (win_vld)
    );

    always_comb begin
        state_n   = state;
        own_n     = own;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        busy_n    = busy;
        preempt_n = 1'b0;

        if (!en) begin
            state_n = IDLE;
            own_n   = '0;
            hold_n  = '0;
            gnt_n   = '0;
            busy_n  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        state_n = OWNED;
                        own_n   = win_id;
                        ptr_n   = IW'(rr_next_ptr(int'(win_id), N));
                        hold_n  = HW'(1);
                        gnt_n   = win;
                        busy_n  = 1'b1;
                    end
                end
                OWNED: begin
                    if (req[own]) begin
                        if (hold_cnt < HW'(MAX_HOLD)) begin
                            hold_n = hold_cnt + HW'(1);
                        end else if (win_vld) begin
                            own_n     = win_id;
                            ptr_n     = IW'(rr_next_ptr(int'(win_id), N));
                            hold_n    = HW'(1);
                            gnt_n     = win;
                            preempt_n = 1'b1;
                        end
                    end else if (win_vld) begin
                        // Release with waiters: hand over without an idle bubble.
                        own_n  = win_id;
                        ptr_n  = IW'(rr_next_ptr(int'(win_id), N));
                        hold_n = HW'(1);
                        gnt_n  = win;
                    end else begin
                        state_n = IDLE;
                        own_n   = '0;
                        hold_n  = '0;
                        gnt_n   = '0;
                        busy_n  = 1'b0;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            own      <= '0;
            ptr      <= IW'(N - 1);
            hold_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            own      <= own_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            busy     <= busy_n;
            preempt  <= preempt_n;
        end
    end

    // The owner register is cleared whenever the grant is, so it doubles as gnt_id.
    assign gnt_id = own;

endmodule

// File: tb/tb_rr_arb4.sv
// Scoreboard bench for rr_arb4 (N=4, MAX_HOLD=8) driven by directed vectors.
module tb_rr_arb4;

    logic       clock;
    logic       reset_n;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       b;
        logic       p;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rr_arb4 #(.N(4), .MAX_HOLD(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d busy=%b pre=%b, want gnt=%b id=%0d busy=%b pre=%b",
                     nm, got[7:4], got[3:2], got[1], got[0], want[7:4], want[3:2], want[1], want[0]);
        end
    endtask

    // Called at a negedge: drive one cycle's inputs, queue the response expected
    // after the coming rising edge, then move on to the next negedge.
    task automatic cyc(input logic [3:0] r, input logic e, input logic [3:0] g,
                       input logic [1:0] id, input logic b, input logic p, input string nm);
        exp_t x;
        req  = r;
        en   = e;
        x.g  = g;
        x.id = id;
        x.b  = b;
        x.p  = p;
        x.nm = nm;
        exp_q.push_back(x);
        @(negedge clock);
    endtask

    // Monitor: compare once per cycle, shortly after the rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk(x.nm, {gnt, gnt_id, busy, preempt}, {x.g, x.id, x.b, x.p});
            end
        end
    end

    initial begin
        int order [5] = '{3, 2, 1, 0, 3};
        logic [3:0] oh;
        reset_n = 1'b0;
        en      = 1'b1;
        req     = 4'b1111;

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_hold", {gnt, gnt_id, busy, preempt}, 8'h00);
        end

        // Release at a negedge; the first edge must grant index 3.
        reset_n = 1'b1;
        for (int b = 0; b < 5; b++) begin
            oh = 4'b0001 << order[b];
            for (int c = 0; c < 8; c++)
                cyc(4'b1111, 1'b1, oh, 2'(order[b]), 1'b1, (b > 0 && c == 0), "burst");
        end

        // Disable mid-grant, then resume from retained pointer (2, not 3).
        cyc(4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, "en_off");
        cyc(4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "en_resume");

        // Owner 2 releases while 0 waits: direct handoff, no preempt.
        cyc(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "own2_hold");
        cyc(4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "own2_hold");
        cyc(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "release_handoff");
        cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "release_idle");

        // Lone requester never gets preempted past the hold limit.
        for (int c = 0; c < 20; c++)
            cyc(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "single_req");
        cyc(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, "single_drop");

        // Owner drops exactly when its hold expires: a release, not a preempt.
        for (int c = 0; c < 8; c++)
            cyc(4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, "expiry_hold");
        cyc(4'b0010, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "expiry_release");

        cyc(4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "pre_reset");
        cyc(4'b0111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, "pre_reset");

        // Asynchronous reset between edges clears outputs at once.
        #7;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {gnt, gnt_id, busy, preempt}, 8'h00);
        @(negedge clock);
        chk("async_reset_held", {gnt, gnt_id, busy, preempt}, 8'h00);
        reset_n = 1'b1;
        cyc(4'b0111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "post_reset_grant");
        cyc(4'b0111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, "post_reset_hold");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Round-robin grant controller that shares one resource among `N` requesters. It is the sequential companion to the team's combinational fixed-priority selector. Grants are registered and one-hot. An owner keeps the grant while it keeps requesting, up to a bounded burst. Priority then rotates so that no requester starves.

## Interface
Parameters:
- `N`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner when others are waiting; legal range 1..255.

Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: arbiter enable.
- `req` input N: request vector, one bit per requester.
- `gnt` output N: registered one-hot grant, or all zeros.
- `gnt_id` output $clog2(N): index of the granted requester; 0 when `gnt` is zero.
- `busy` output 1: high exactly when `gnt` is non-zero.
- `preempt` output 1: one-cycle pulse when a grant was taken away by the `MAX_HOLD` limit.

## Operation
- State: FSM {IDLE, OWNED}, owner index `own`, rotation pointer `ptr` ($clog2(N) bits), hold counter `hold_cnt` ($clog2(MAX_HOLD+1) bits, saturating).
- Search order from `ptr` is descending with wrap: `ptr`, `ptr-1`, …, 0, N-1, …, `ptr+1`. The first asserted bit in that order wins.
- `ptr` resets to N-1, so the first arbitration after reset gives highest index = highest priority.
- After each new grant to index k, `ptr` becomes (k-1) mod N, so k becomes lowest priority.
- IDLE:
  - If `en` and `req` is non-zero, grant the winner.
  - Then go to OWNED with `own`=winner and `hold_cnt`=1.
- OWNED, `en`=1, `req[own]`=1, `hold_cnt` < `MAX_HOLD`:
  - Keep the grant and increment `hold_cnt`.
- OWNED, `en`=1, `req[own]`=1, `hold_cnt` = `MAX_HOLD`:
  - If any other requester is asserted, grant the search winner excluding `own`, set `hold_cnt`=1, and pulse `preempt`.
  - Otherwise keep the grant; `hold_cnt` stays saturated.
- OWNED, `en`=1, `req[own]`=0 (release):
  - If other requests exist, hand the grant to the search winner with no idle bubble and set `hold_cnt`=1. No `preempt` pulse.
  - Otherwise go to IDLE with `gnt`=0.
- `en`=0 in any state:
  - Next edge: IDLE, `gnt`=0, `hold_cnt`=0.
  - `ptr` is retained.
- Requests that go 0→1 while the resource is owned wait their turn in rotation. No request is queued beyond the level of `req`.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `preempt`=0, state IDLE, `ptr`=N-1, `hold_cnt`=0.
- Latency: `req` sampled at edge t drives `gnt` from edge t onward, i.e. visible in the cycle after the request is first presented.
- Release latency:
  - Owner drops `req` in cycle c; `gnt` moves or clears at the edge ending cycle c.
  - The owner therefore holds `gnt` for exactly the cycles it presented `req`.
- Grant duration: under contention, one owner holds `gnt` for at most `MAX_HOLD` consecutive cycles.
- `preempt` is registered and high in the same cycle as the new `gnt`.
- Simultaneous owner release and hold expiry: treated as a release, with no `preempt`.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously). The rotation restarts from N-1.
- All outputs come straight from flops; there is no combinational path from `req` or `en` to any output.

## Structure
- Shared package `arb_pkg`: FSM state enum `arb_state_t` {IDLE, OWNED}, and a `rr_next_ptr` function computing (k-1) mod N.
- Sub-module `ps_rot`: a purely combinational N-wide rotating priority selector.
  - Inputs: `req`, `ptr`, and an exclude mask.
  - Outputs: one-hot winner and index.
  - The FSM, counter and output registers live in `rr_arb4`.

## Test plan
- Reset with `req`=4'b1111, `en`=1 → `gnt`=0 during reset. First edge after `reset_n` rises gives `gnt`=4'b1000, `gnt_id`=3, `busy`=1.
- All four requesting with `MAX_HOLD`=8:
  - Grants hold 8 cycles each in the order 3,2,1,0,3.
  - `preempt` pulses at each of the four handoffs.
- Owner 2 drops `req` after 3 cycles while `req[0]`=1:
  - `gnt` goes 4'b0100 → 4'b0001 at that edge with no zero cycle.
  - `preempt` stays 0.
- Single requester `req`=4'b0010 held for 20 cycles → `gnt`=4'b0010 continuously, `preempt` never pulses.
- `en` dropped mid-grant → `gnt`=0 at the next edge. When `en` is restored, search resumes from the retained `ptr`, not from 3.
- `reset_n` pulsed low mid-burst (asynchronous, between edges) → outputs clear immediately. After release, the next grant goes to the highest asserted index.
